// File: rtl/enc_pkg.sv
// Shared HDC record-encoder types, constants and elaboration helpers.
package enc_pkg;

    localparam int ENC_HV_DIM        = 4096;
    localparam int ENC_FEATURE_COUNT = 617;

    typedef enum logic [1:0] {
        IDLE,
        BUNDLE,
        HOLD
    } enc_state_t;

    // Rotate-left amount applied to feature f before bundling.
    function automatic int rot_amt(input int f, input int base, input int n);
        return (f + base) % n;
    endfunction

    function automatic int cnt_w(input int fc);
        return $clog2(fc + 1);
    endfunction

endpackage

// File: rtl/enc_majority_bundler.sv
// One output dimension: popcount over all features, strict threshold, prune gate.
module enc_majority_bundler
    import enc_pkg::*;
#(
    parameter int          FEATURE_COUNT = ENC_FEATURE_COUNT,
    parameter int unsigned THRESH        = FEATURE_COUNT / 2
) (
    input  logic [FEATURE_COUNT-1:0] feat_bits,
    input  logic                     prune,
    output logic                     bit_out
);

    localparam int CW = cnt_w(FEATURE_COUNT);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int f = 0; f < FEATURE_COUNT; f++) begin
            cnt = cnt + CW'(feat_bits[f]);
        end
    end

    assign bit_out = (32'(cnt) > THRESH) && !prune;

endmodule

// File: rtl/enc_pruned_encoder.sv
// HDC record encoder: rotate-bind per feature, then masked majority bundling
// one slice of DIMS_PER_CC dimensions per cycle, with a valid/ready result.
module enc_pruned_encoder
    import enc_pkg::*;
#(
    parameter int          HV_DIM        = ENC_HV_DIM,
    parameter int          FEATURE_COUNT = ENC_FEATURE_COUNT,
    parameter int          DIMS_PER_CC   = 1024,
    parameter int          SHIFT_BASE    = 1,
    parameter int unsigned THRESH        = FEATURE_COUNT / 2,
    localparam int         SEQ_CYCLES    = HV_DIM / DIMS_PER_CC,
    localparam int         CTR_W         = (SEQ_CYCLES > 1) ? $clog2(SEQ_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [HV_DIM-1:0] level_hvs [FEATURE_COUNT],
    input  logic [HV_DIM-1:0] dim_mask,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] encoded_hv,
    output logic [CTR_W-1:0]  ctr
);

    if (HV_DIM % DIMS_PER_CC != 0) begin : g_bad_slice
        $error("DIMS_PER_CC must divide HV_DIM");
    end

    // Vectors are kept slice-major so the active slice is a plain index.
    typedef logic [SEQ_CYCLES-1:0][DIMS_PER_CC-1:0] slice_vec_t;

    enc_state_t state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic busy_q, busy_d;
    logic out_valid_q, out_valid_d;
    slice_vec_t enc_q, enc_d;
    slice_vec_t mask_q, mask_d;
    slice_vec_t bound_q [FEATURE_COUNT];
    slice_vec_t bound_d [FEATURE_COUNT];
    slice_vec_t rot_hv [FEATURE_COUNT];
    logic [DIMS_PER_CC-1:0] slice_bits;

    for (genvar f = 0; f < FEATURE_COUNT; f++) begin : g_rot
        localparam int S = rot_amt(f, SHIFT_BASE, HV_DIM);
        assign rot_hv[f] = slice_vec_t'((level_hvs[f] << S)
                                      | (level_hvs[f] >> (HV_DIM - S)));
    end

    for (genvar j = 0; j < DIMS_PER_CC; j++) begin : g_dim
        logic [FEATURE_COUNT-1:0] feat;

        always_comb begin
            feat = '0;
            for (int f = 0; f < FEATURE_COUNT; f++) begin
                feat[f] = bound_q[f][ctr_q][j];
            end
        end

        enc_majority_bundler #(
            .FEATURE_COUNT(FEATURE_COUNT),
            .THRESH       (THRESH)
        ) u_bundler (
            .feat_bits(feat),
            .prune    (mask_q[ctr_q][j]),
            .bit_out  (slice_bits[j])
        );
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        enc_d       = enc_q;
        mask_d      = mask_q;
        bound_d     = bound_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bound_d = rot_hv;
                        mask_d  = slice_vec_t'(dim_mask);
                        enc_d   = '0;
                        ctr_d   = '0;
                        busy_d  = 1'b1;
                        state_d = BUNDLE;
                    end
                end
                BUNDLE: begin
                    enc_d[ctr_q] = slice_bits;
                    if (ctr_q == CTR_W'(SEQ_CYCLES - 1)) begin
                        ctr_d       = '0;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            enc_q       <= '0;
            mask_q      <= '0;
            bound_q     <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            enc_q       <= enc_d;
            mask_q      <= mask_d;
            bound_q     <= bound_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign encoded_hv = enc_q;
    assign ctr        = ctr_q;

endmodule

// File: tb/tb_enc_pruned_encoder.sv
// Self-checking bench: constant vector table, hand sequences, random vs model.
module tb_enc_pruned_encoder;

    localparam int HV = 16;
    localparam int FC = 3;
    localparam int DPC = 4;
    localparam int SEQ = HV / DPC;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b1;
    logic start = 1'b0;
    logic [HV-1:0] level_hvs [FC];
    logic [HV-1:0] dim_mask = '0;
    logic busy, out_valid;
    logic out_ready = 1'b0;
    logic [HV-1:0] encoded_hv;
    logic [1:0] ctr;

    int total = 0;
    int bad = 0;

    enc_pruned_encoder #(
        .HV_DIM       (HV),
        .FEATURE_COUNT(FC),
        .DIMS_PER_CC  (DPC),
        .SHIFT_BASE   (1),
        .THRESH       (1)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .start     (start),
        .level_hvs (level_hvs),
        .dim_mask  (dim_mask),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .encoded_hv(encoded_hv),
        .ctr       (ctr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HV-1:0] h0, h1, h2, m;
        bit scr;
        logic [HV-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: rotate-left bind, count ones per dimension, strict majority.
    function automatic logic [HV-1:0] model(input logic [HV-1:0] h0,
                                            input logic [HV-1:0] h1,
                                            input logic [HV-1:0] h2,
                                            input logic [HV-1:0] m);
        logic [HV-1:0] hv [FC];
        logic [HV-1:0] r;
        hv[0] = h0; hv[1] = h1; hv[2] = h2;
        r = '0;
        for (int d = 0; d < HV; d++) begin
            int cnt = 0;
            for (int f = 0; f < FC; f++) begin
                int s = (f + 1) % HV;
                cnt += int'(hv[f][(d - s + HV) % HV]);
            end
            r[d] = (cnt > 1) && !m[d];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at one edge, optionally scramble inputs, wait for out_valid,
    // then complete the handshake.
    task automatic do_encode(input logic [HV-1:0] h0, input logic [HV-1:0] h1,
                             input logic [HV-1:0] h2, input logic [HV-1:0] m,
                             input bit scr, output logic [HV-1:0] res,
                             output int lat);
        level_hvs[0] = h0; level_hvs[1] = h1; level_hvs[2] = h2;
        dim_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scr) begin
            dim_mask = '0;
            level_hvs[0] = 16'($urandom);
            level_hvs[1] = 16'($urandom);
            level_hvs[2] = 16'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = encoded_hv;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t tbl [5];
    logic [HV-1:0] res, snap;
    int lat;

    initial begin
        level_hvs[0] = '0; level_hvs[1] = '0; level_hvs[2] = '0;
        tbl[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF};
        tbl[1] = '{16'h0008, 16'h0004, 16'h0000, 16'h0000, 1'b0, 16'h0010};
        tbl[2] = '{16'h0008, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF, 1'b1, 16'hFF00};
        tbl[4] = '{16'h0001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 16'h0000};

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_enc", 32'(encoded_hv), 0);
        chk("rst_ctr", 32'(ctr), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Detailed timing of an all-ones encode.
        level_hvs[0] = '1; level_hvs[1] = '1; level_hvs[2] = '1;
        dim_mask = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t0_busy", 32'(busy), 1);
        chk("t0_ctr", 32'(ctr), 0);
        chk("t0_valid", 32'(out_valid), 0);
        for (int k = 1; k < SEQ; k++) begin
            tick();
            chk("seq_ctr", 32'(ctr), 32'(k));
            chk("seq_busy", 32'(busy), 1);
            chk("seq_valid", 32'(out_valid), 0);
        end
        tick();
        chk("done_valid", 32'(out_valid), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_ctr", 32'(ctr), 0);
        chk("done_enc", 32'(encoded_hv), 32'h0000FFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_valid", 32'(out_valid), 0);
        chk("hs_keep", 32'(encoded_hv), 32'h0000FFFF);

        foreach (tbl[i]) begin
            do_encode(tbl[i].h0, tbl[i].h1, tbl[i].h2, tbl[i].m, tbl[i].scr,
                      res, lat);
            chk("tbl_enc", 32'(res), 32'(tbl[i].exp));
            chk("tbl_lat", 32'(lat), SEQ);
        end

        // Two-cycle stall at ctr=1.
        level_hvs[0] = '1; level_hvs[1] = '1; level_hvs[2] = '1;
        dim_mask = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("stall_ctr0", 32'(ctr), 1);
        snap = encoded_hv;
        en = 1'b0;
        repeat (2) begin
            tick();
            chk("stall_ctr", 32'(ctr), 1);
            chk("stall_enc", 32'(encoded_hv), 32'(snap));
            chk("stall_busy", 32'(busy), 1);
        end
        en = 1'b1;
        repeat (2) tick();
        chk("stall_ctr3", 32'(ctr), 3);
        chk("stall_novalid", 32'(out_valid), 0);
        tick();
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_enc_final", 32'(encoded_hv), 32'h0000FFFF);

        // Back-pressure in HOLD with start ignored, including on handshake.
        level_hvs[0] = 16'h0008; level_hvs[1] = 16'h0004; level_hvs[2] = '0;
        start = 1'b1;
        repeat (3) begin
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_busy", 32'(busy), 0);
            chk("hold_enc", 32'(encoded_hv), 32'h0000FFFF);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_exit_valid", 32'(out_valid), 0);
        chk("hold_exit_busy", 32'(busy), 0);
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("restart_lat", 32'(lat), SEQ);
        chk("restart_enc", 32'(encoded_hv), 32'h00000010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of bundling.
        level_hvs[0] = '1; level_hvs[1] = '1; level_hvs[2] = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("pre_rst_ctr", 32'(ctr), 2);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_enc", 32'(encoded_hv), 0);
        chk("arst_ctr", 32'(ctr), 0);
        @(negedge clk);
        nrst = 1'b1;
        do_encode(16'h0008, 16'h0004, 16'h0000, 16'h0000, 1'b0, res, lat);
        chk("post_rst_enc", 32'(res), 32'h00000010);
        chk("post_rst_lat", 32'(lat), SEQ);

        // Random vectors against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [HV-1:0] a, b, c, m;
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            m = (i % 3 == 0) ? 16'($urandom) : '0;
            do_encode(a, b, c, m, i[0], res, lat);
            chk("rnd_enc", 32'(res), 32'(model(a, b, c, m)));
            chk("rnd_lat", 32'(lat), SEQ);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_pruned_encoder.md
Name: enc_pruned_encoder

Overview:
Parametrised next-generation HDC record encoder. For each feature, it binds the level hypervector (HV) by a per-feature cyclic rotation. It then bundles all features by a thresholded majority, time-multiplexed over HV_DIM/DIMS_PER_CC cycles. Unlike the current encoder, it adds a per-dimension redundancy-pruning mask, a configurable threshold, stall via en, and a valid/ready output handshake. It sits between the level-HV lookup stage and the classifier/similarity stage.

Parameters:
HV_DIM, 4096, hypervector width in bits
FEATURE_COUNT, 617, number of features bound and bundled
DIMS_PER_CC, 1024, dimensions bundled per cycle; must divide HV_DIM (elaboration-time assertion)
SHIFT_BASE, 1, feature f is rotated by (f+SHIFT_BASE) mod HV_DIM
THRESH, FEATURE_COUNT/2, a dimension outputs 1 iff its popcount > THRESH
SEQ_CYCLES, HV_DIM/DIMS_PER_CC, derived; not overridable
CTR_W, max(1,$clog2(SEQ_CYCLES)), derived

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  reset, asynchronous, active-low
en  input  1  global enable; low freezes FSM, counter and all registers
start  input  1  request an encode; accepted only in IDLE with en=1
level_hvs  input  [HV_DIM-1:0] x FEATURE_COUNT (unpacked)  level HVs, sampled on accept
dim_mask  input  HV_DIM  1 = dimension pruned; sampled on accept
busy  output  1  high in LATCH and BUNDLE
out_valid  output  1  encoded_hv valid (HOLD state)
out_ready  input  1  consumer accepts result
encoded_hv  output  HV_DIM  encoded HV
ctr  output  CTR_W  current bundling slice index

Behaviour:
- Reset (nrst low, any state, asynchronous): state=IDLE; ctr=0; busy=0; out_valid=0; encoded_hv=0; bound and mask registers=0.
- All register updates require en=1. en=0 holds every register and output unchanged and does not alter latency other than by the stalled cycles.
- IDLE: when start=1, capture the rotated level_hvs into bound registers and capture dim_mask; clear encoded_hv; ctr=0; move to BUNDLE. The capture cycle is the LATCH phase, so busy=1 from the next cycle.
- Rotation: bound[f][d] = level_hvs[f][(d - s_f) mod HV_DIM], with s_f=(f+SHIFT_BASE) mod HV_DIM (rotate-left). s_f=0 is allowed and means identity.
- BUNDLE: each cycle, for d in slice ctr*DIMS_PER_CC .. +DIMS_PER_CC-1:
  - cnt = popcount over f of bound[f][d], width $clog2(FEATURE_COUNT+1);
  - encoded_hv[d] = (cnt > THRESH) && !mask[d].
  - Then ctr increments. On ctr==SEQ_CYCLES-1, ctr wraps to 0 and the FSM moves to HOLD.
- Latency: start accepted at edge T; slices are written at edges T+1..T+SEQ_CYCLES; out_valid=1 from T+SEQ_CYCLES+1, with no stalls.
- HOLD: out_valid=1 and encoded_hv stable. On out_valid && out_ready && en, go to IDLE; out_valid falls next cycle and encoded_hv is retained.
- start is ignored outside IDLE. There is no queuing; a start coinciding with the HOLD-to-IDLE handshake is ignored.
- Changes to level_hvs and dim_mask after accept have no effect on the current encode.
- Even FEATURE_COUNT with cnt == THRESH produces 0 (strict compare).

Decomposition:
- Package enc_pkg:
  - state enum typedef enc_state_t {IDLE, BUNDLE, HOLD};
  - functions for rotation index and popcount width;
  - shared HDC constants (default HV_DIM, FEATURE_COUNT).
- Sub-module enc_majority_bundler, parametrised (FEATURE_COUNT, THRESH): takes the feature-bit vector and prune bit, outputs the thresholded bit. It is instantiated DIMS_PER_CC times behind the slice mux.
- The FSM, bound registers, slice mux and output register stay in the top module.

Test Plan (bench parameters HV_DIM=16, FEATURE_COUNT=3, DIMS_PER_CC=4, SHIFT_BASE=1, THRESH=1):
- All level_hvs=16'hFFFF, dim_mask=0, start pulse at T -> encoded_hv=16'hFFFF; out_valid rises at T+5; busy high T+1..T+4; ctr sequence 0,1,2,3.
- level_hvs={16'h0008,16'h0004,16'h0000} (features 0,1,2) -> popcount 2 at dimension 4 -> encoded_hv=16'h0010. Repeat with level_hvs[1]=0 -> 16'h0000.
- All-ones inputs with dim_mask=16'h00FF; change dim_mask to 0 one cycle after start -> encoded_hv=16'hFF00.
- en held low for 2 cycles during BUNDLE (at ctr=1) -> ctr and encoded_hv frozen during the stall; out_valid at T+7; result identical to the unstalled run.
- out_ready low for 3 cycles in HOLD, start pulsed meanwhile -> encoded_hv stable, start ignored, no busy. out_ready=1 -> IDLE next cycle; a new start is then accepted.
- nrst asserted at ctr=2 mid-BUNDLE -> immediately busy=0, out_valid=0, encoded_hv=0, ctr=0. After release, a fresh encode gives the correct result.
